// File: rtl/wide_mul_seq.sv
// rtl/wide_mul_seq.sv - sequential wide multiplier built from one narrow multiplier pass per multiplier slice
//
// Computes out = a * b mod 2^OUT_WIDTH. Each pass multiplies the latched
// multiplicand by one SLICE_WIDTH-bit slice of the latched multiplier. The
// shifted partial products are summed into an accumulator.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid           in_ready   block can accept operands
//   a          multiplicand (A_WIDTH)       b          multiplier (B_WIDTH)
//   out_valid  result valid                 out_ready  consumer accepts result
//   out        product (OUT_WIDTH), 0 while out_valid is low
//   busy       high whenever not idle
module wide_mul_seq #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 32,
    parameter int SLICE_WIDTH = 16,
    parameter int OUT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 busy
);

    localparam int N  = B_WIDTH / SLICE_WIDTH;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = A_WIDTH + SLICE_WIDTH;
    localparam int EW = (OUT_WIDTH > PW) ? OUT_WIDTH : PW;

    generate
        if ((B_WIDTH % SLICE_WIDTH) != 0 || N < 1) begin : g_bad_params
            $error("wide_mul_seq: B_WIDTH must be a non-zero multiple of SLICE_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic [KW-1:0]        k_q, k_d;
    logic [PW-1:0]        prod_q, prod_d;
    // Slice index whose partial product currently sits in prod_q, and
    // whether prod_q holds a partial product of this operation at all.
    logic [KW-1:0]        pk_q, pk_d;
    logic                 pvld_q, pvld_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;

    logic [SLICE_WIDTH-1:0] slice;
    logic [PW-1:0]          mul;
    logic [31:0]            shamt;
    logic [EW-1:0]          partial;
    logic [OUT_WIDTH-1:0]   acc_sum;

    // The only multiplier in the block.
    always_comb begin
        slice   = b_q[k_q*SLICE_WIDTH +: SLICE_WIDTH];
        mul     = PW'(a_q) * PW'(slice);
        shamt   = 32'(pk_q) * 32'(SLICE_WIDTH);
        partial = EW'(prod_q) << shamt;
        // Carries above OUT_WIDTH are discarded by truncation here.
        acc_sum = acc_q + partial[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        prod_d    = prod_q;
        pk_d      = pk_q;
        pvld_d    = pvld_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    k_d     = '0;
                    pvld_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                prod_d = mul;
                pk_d   = k_q;
                pvld_d = 1'b1;
                // The first RUN cycle has no partial product yet.
                if (pvld_q) begin
                    acc_d = acc_sum;
                end
                if (k_q == KW'(N - 1)) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                acc_d   = acc_sum;
                pvld_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out       = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            prod_q <= '0;
            pk_q   <= '0;
            pvld_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            prod_q <= prod_d;
            pk_q   <= pk_d;
            pvld_q <= pvld_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: tb/tb_wide_mul_seq.sv
// tb/tb_wide_mul_seq.sv - self-checking scoreboard bench for wide_mul_seq
module tb_wide_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    logic [31:0] sb_q[$];

    wide_mul_seq #(
        .A_WIDTH    (16),
        .B_WIDTH    (32),
        .SLICE_WIDTH(16),
        .OUT_WIDTH  (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (op_a),
        .b        (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (res),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {48'd0, x} * {32'd0, y};
        return p[31:0];
    endfunction

    // Book-keep the handshakes that the coming rising edge will perform,
    // then advance to the next falling edge.
    task automatic tick();
        logic [31:0] e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(model(op_a, op_b));
            end
            if (out_valid && out_ready) begin
                n_out++;
                check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_out", res, e);
                end
            end
            if (!out_valid) begin
                check("out_zero_when_invalid", res, 0);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input string tag);
        int w;
        int lat;
        w        = 0;
        op_a     = x;
        op_b     = y;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_accept"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        op_a     = ~x;
        op_b     = ~y;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        out_ready = 1'b1;
        check({tag, "_out"}, res, exp);
        tick();
    endtask

    initial begin
        int lat;
        int start_out;
        int iter;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", res, 0);
        check("rst_busy", busy, 0);

        // 3 * 5 with explicit edge-by-edge latency
        op_a     = 16'd3;
        op_b     = 32'd5;
        in_valid = 1'b1;
        check("a3b5_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        op_a     = 16'hABCD;
        op_b     = 32'h1234_5678;
        check("a3b5_busy", busy, 1);
        check("a3b5_in_ready_run", in_ready, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("a3b5_valid_by_edge", out_valid, 64'(i == 3));
        end
        check("a3b5_out", res, 32'h0000_000F);
        tick();
        check("a3b5_in_ready_after", in_ready, 1);

        run_op(16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_0001, "wrap");
        run_op(16'h1234, 32'h0001_0000, 32'h1234_0000, "slice1");
        run_op(16'h0000, 32'hDEAD_BEEF, 32'h0000_0000, "zero_a");

        // Backpressure in DONE
        out_ready = 1'b0;
        op_a      = 16'd5;
        op_b      = 32'd6;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 3);
        op_a     = 16'd7;
        op_b     = 32'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", out_valid, 1);
            check("bp_out_hold", res, 32'd30);
            check("bp_in_ready_low", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_out_release", res, 32'd30);
        tick();
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_second_latency", lat, 3);
        check("bp_second_out", res, 32'h31);
        tick();

        // Reset mid-RUN, with in_valid asserted alongside reset
        op_a     = 16'hFFFF;
        op_b     = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrun_busy", busy, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_out", res, 0);
        check("midrun_rst_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            check("midrun_no_pulse", out_valid, 0);
            tick();
        end
        run_op(16'd2, 32'd9, 32'h12, "after_rst");

        // Random back-to-back traffic with random consumer stalls
        start_out = n_out;
        iter      = 0;
        while ((n_out - start_out) < 10000 && iter < 80000) begin
            in_valid  = 1'b1;
            op_a      = 16'($urandom_range(0, 65535));
            op_b      = $urandom();
            out_ready = ($urandom_range(0, 7) != 0);
            tick();
            iter++;
        end
        check("random_results", n_out - start_out, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            tick();
        end
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wide_mul_seq.md
WIDE_MUL_SEQ -- requirements
Module: wide_mul_seq

Interface
REQ-001 Parameter A_WIDTH, default 16, unsigned multiplicand width.
REQ-002 Parameter B_WIDTH, default 32, unsigned multiplier width.
REQ-003 Parameter SLICE_WIDTH, default 16, multiplier-slice width per DSP pass; N = B_WIDTH/SLICE_WIDTH.
REQ-004 Parameter OUT_WIDTH, default 32, result width; result truncated modulo 2^OUT_WIDTH.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand pair a/b valid.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 a  input  A_WIDTH  multiplicand.
REQ-010 b  input  B_WIDTH  multiplier.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  OUT_WIDTH  product a*b mod 2^OUT_WIDTH.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Elaboration SHALL fail if B_WIDTH is not a multiple of SLICE_WIDTH or N < 1.
REQ-016 Exactly one A_WIDTH x SLICE_WIDTH unsigned multiplier SHALL exist, followed by one product register (DSP MREG-style); no other multipliers.
REQ-017 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: in_ready=1; on in_valid&&in_ready, latch a, b into operand registers, clear accumulator, slice counter k=0, go RUN.
REQ-019 RUN: present b[k*SLICE_WIDTH +: SLICE_WIDTH] to multiplier; product register loads a*slice_k each edge; k increments; after k=N-1 go DRAIN.
REQ-020 Accumulate: one cycle after product register loads slice k, acc <= acc + (product << k*SLICE_WIDTH), truncated to OUT_WIDTH bits; carries beyond OUT_WIDTH discarded.
REQ-021 DRAIN: exactly one cycle, accumulates final partial product, go DONE.
REQ-022 DONE: out_valid=1, out=acc; out SHALL hold stable while out_valid && !out_ready; on out_ready go IDLE.
REQ-023 Latency: out_valid SHALL first be high in the cycle after the (N+1)th rising edge following the accepting edge (N=2: 3 edges).
REQ-024 in_ready SHALL be 0 in RUN, DRAIN, DONE; in_valid there SHALL be ignored and operands not latched.
REQ-025 Result accepted (out_valid&&out_ready) and new input cannot coincide; next accept earliest in IDLE cycle after DONE exit.
REQ-026 Operand changes on a/b after acceptance SHALL not affect the in-flight result.
REQ-027 Zero operands SHALL follow the same full-length schedule (no early termination).
REQ-028 out SHALL be 0 whenever out_valid is 0.

Reset
REQ-029 rst high at an edge SHALL force IDLE, k=0, acc=0, product register=0, out_valid=0, out=0, busy=0, in_ready=1 in the following cycle.
REQ-030 rst asserted mid-RUN/DRAIN/DONE SHALL discard the in-flight operation; no out_valid pulse results from it.
REQ-031 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-032 a=3, b=5, out_ready=1 -> out_valid high 3 edges after accept with out=0x0000000F, then in_ready=1 next cycle.
REQ-033 a=0xFFFF, b=0xFFFFFFFF -> out=0xFFFF0001 (wrap-around truncation).
REQ-034 a=0x1234, b=0x00010000 -> out=0x12340000 (only slice 1 non-zero); a=0, b=0xDEADBEEF -> out=0 with identical latency.
REQ-035 Backpressure: out_ready low 5 cycles in DONE -> out_valid and out stable, in_ready=0, in_valid with a=7,b=7 not accepted; out_ready high -> IDLE, then a=7,b=7 accepted and out=0x31.
REQ-036 Reset mid-RUN with a=0xFFFF, b=0xFFFFFFFF -> next cycle IDLE, out_valid=0, out=0; following a=2, b=9 -> out=0x12.
REQ-037 Random: 10000 back-to-back operations with random out_ready stalls; every out SHALL equal (a*b) mod 2^32 in order, none dropped or duplicated.
